// File: rtl/miriscv_lsu_pkg.sv
// Shared miriscv LSU definitions: load/store size encodings, FSM states, request payload
// and the store-side alignment helpers.
package miriscv_lsu_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;

  localparam logic [2:0] LDST_B  = 3'b000;
  localparam logic [2:0] LDST_H  = 3'b001;
  localparam logic [2:0] LDST_W  = 3'b010;
  localparam logic [2:0] LDST_BU = 3'b100;
  localparam logic [2:0] LDST_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_RESP = 2'd2
  } lsu_state_e;

  typedef struct packed {
    logic            we;
    logic [BE_W-1:0] be;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } lsu_bus_req_t;

  // Unknown funct3, unsigned stores, or an address not aligned to the access size
  function automatic logic lsu_illegal(input logic we, input logic [2:0] size,
                                       input logic [1:0] addr_lo);
    logic bad;
    case (size)
      LDST_B:  bad = 1'b0;
      LDST_H:  bad = addr_lo[0];
      LDST_W:  bad = (addr_lo != 2'b00);
      LDST_BU: bad = we;
      LDST_HU: bad = we | addr_lo[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [BE_W-1:0] lsu_be(input logic [2:0] size, input logic [1:0] addr_lo);
    logic [BE_W-1:0] be;
    case (size)
      LDST_B, LDST_BU: be = 4'b0001 << addr_lo;
      LDST_H, LDST_HU: be = 4'b0011 << {addr_lo[1], 1'b0};
      default:         be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate the store operand across every lane so the byte enables pick the right one
  function automatic logic [XLEN-1:0] lsu_wdata(input logic [2:0] size, input logic [XLEN-1:0] d);
    logic [XLEN-1:0] w;
    case (size)
      LDST_B, LDST_BU: w = {4{d[7:0]}};
      LDST_H, LDST_HU: w = {2{d[15:0]}};
      default:         w = d;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/miriscv_lsu_if.sv
// Data-memory bus with a req/gnt/rvalid handshake and one outstanding transaction.
interface miriscv_lsu_if;

  logic                                 req;
  logic                                 we;
  logic [miriscv_lsu_pkg::BE_W-1:0]     be;
  logic [miriscv_lsu_pkg::XLEN-1:0]     addr;
  logic [miriscv_lsu_pkg::XLEN-1:0]     wdata;
  logic                                 gnt;
  logic                                 rvalid;
  logic [miriscv_lsu_pkg::XLEN-1:0]     rdata;

  modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/miriscv_lsu_ext.sv
// Load extractor: selects the addressed byte/half of the read word and sign/zero-extends it.
module miriscv_lsu_ext
  import miriscv_lsu_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      size,
  output logic [XLEN-1:0] result_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'(rdata >> {addr_lo, 3'b000});
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      LDST_B:  result_c = {{24{byte_sel[7]}}, byte_sel};
      LDST_BU: result_c = {24'd0, byte_sel};
      LDST_H:  result_c = {{16{half_sel[15]}}, half_sel};
      LDST_HU: result_c = {16'd0, half_sel};
      default: result_c = rdata;
    endcase
  end

endmodule

// File: rtl/miriscv_lsu.sv
// miriscv load/store unit: issues one data-memory transaction per load/store and
// stalls the core until the memory responds.
module miriscv_lsu
  import miriscv_lsu_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,

  input  logic             lsu_req_i,
  input  logic             lsu_we_i,
  input  logic [2:0]       lsu_size_i,
  input  logic [XLEN-1:0]  lsu_addr_i,
  input  logic [XLEN-1:0]  lsu_data_i,
  output logic [XLEN-1:0]  lsu_data_o,
  output logic             lsu_stall_req_o,
  output logic             lsu_err_o,

  miriscv_lsu_if.master    data
);

  lsu_state_e   state_q, state_d;
  lsu_bus_req_t bus_q, bus_d;
  logic         req_q, req_d;
  logic [2:0]   size_q, size_d;
  logic [1:0]   addr_lo_q, addr_lo_d;
  logic [XLEN-1:0] ext_data;
  logic         done;

  assign lsu_err_o = lsu_req_i & lsu_illegal(lsu_we_i, lsu_size_i, lsu_addr_i[1:0]);
  assign done      = (state_q == LSU_RESP) & data.rvalid;

  assign lsu_stall_req_o = ~rst_i & lsu_req_i & ~lsu_err_o & ~done;

  // Next-state and request-register update; inputs are only sampled in IDLE
  always_comb begin
    state_d   = state_q;
    bus_d     = bus_q;
    req_d     = req_q;
    size_d    = size_q;
    addr_lo_d = addr_lo_q;
    case (state_q)
      LSU_IDLE: begin
        if (lsu_req_i && !lsu_err_o) begin
          state_d     = LSU_REQ;
          req_d       = 1'b1;
          bus_d.we    = lsu_we_i;
          bus_d.be    = lsu_be(lsu_size_i, lsu_addr_i[1:0]);
          bus_d.addr  = {lsu_addr_i[XLEN-1:2], 2'b00};
          bus_d.wdata = lsu_wdata(lsu_size_i, lsu_data_i);
          size_d      = lsu_size_i;
          addr_lo_d   = lsu_addr_i[1:0];
        end
      end
      LSU_REQ: begin
        if (data.gnt) begin
          state_d = LSU_RESP;
          req_d   = 1'b0;
        end
      end
      LSU_RESP: begin
        if (data.rvalid) state_d = LSU_IDLE;
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= LSU_IDLE;
      bus_q     <= '0;
      req_q     <= 1'b0;
      size_q    <= LDST_B;
      addr_lo_q <= 2'b00;
    end else begin
      state_q   <= state_d;
      bus_q     <= bus_d;
      req_q     <= req_d;
      size_q    <= size_d;
      addr_lo_q <= addr_lo_d;
    end
  end

  assign data.req   = req_q;
  assign data.we    = bus_q.we;
  assign data.be    = bus_q.be;
  assign data.addr  = bus_q.addr;
  assign data.wdata = bus_q.wdata;

  miriscv_lsu_ext u_ext (
    .rdata    (data.rdata),
    .addr_lo  (addr_lo_q),
    .size     (size_q),
    .result_c (ext_data)
  );

  // Load result is only presented in the completion cycle; stores return zero
  assign lsu_data_o = (~rst_i & done & ~bus_q.we) ? ext_data : '0;

endmodule

// File: tb/tb_miriscv_lsu.sv
// Directed self-checking bench for miriscv_lsu: loads, stores, wait states, errors, reset abort.
module tb_miriscv_lsu;
  import miriscv_lsu_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        lsu_req_i, lsu_we_i;
  logic [2:0]  lsu_size_i;
  logic [31:0] lsu_addr_i, lsu_data_i, lsu_data_o;
  logic        lsu_stall_req_o, lsu_err_o;

  int total = 0;
  int bad   = 0;
  int n_hs  = 0;
  int hs0;

  miriscv_lsu_if bus ();

  miriscv_lsu dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .lsu_req_i       (lsu_req_i),
    .lsu_we_i        (lsu_we_i),
    .lsu_size_i      (lsu_size_i),
    .lsu_addr_i      (lsu_addr_i),
    .lsu_data_i      (lsu_data_i),
    .lsu_data_o      (lsu_data_o),
    .lsu_stall_req_o (lsu_stall_req_o),
    .lsu_err_o       (lsu_err_o),
    .data            (bus)
  );

  always #5 clk_i = ~clk_i;

  // Count accepted requests (req & gnt at a rising edge)
  always @(posedge clk_i) if (bus.req === 1'b1 && bus.gnt === 1'b1) n_hs++;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Minimum-latency load: gnt with the request, rvalid the following cycle
  task automatic do_load(input string tag, input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [3:0] be, input logic [31:0] exp);
    @(negedge clk_i);
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = size; lsu_addr_i = addr;
    bus.gnt = 1'b0; bus.rvalid = 1'b0;
    #1;
    chk({tag, " c0 stall"}, 32'(lsu_stall_req_o), 32'd1);
    chk({tag, " c0 req"},   32'(bus.req), 32'd0);
    @(negedge clk_i);
    bus.gnt = 1'b1;
    #1;
    chk({tag, " c1 req"},   32'(bus.req), 32'd1);
    chk({tag, " c1 addr"},  bus.addr, {addr[31:2], 2'b00});
    chk({tag, " c1 be"},    32'(bus.be), 32'(be));
    chk({tag, " c1 we"},    32'(bus.we), 32'd0);
    chk({tag, " c1 stall"}, 32'(lsu_stall_req_o), 32'd1);
    @(negedge clk_i);
    bus.gnt = 1'b0; bus.rvalid = 1'b1; bus.rdata = rdata;
    #1;
    chk({tag, " c2 req"},   32'(bus.req), 32'd0);
    chk({tag, " c2 stall"}, 32'(lsu_stall_req_o), 32'd0);
    chk({tag, " c2 data"},  lsu_data_o, exp);
    @(negedge clk_i);
    lsu_req_i = 1'b0; bus.rvalid = 1'b0;
    #1;
    chk({tag, " c3 data"},  lsu_data_o, 32'd0);
  endtask

  initial begin
    rst_i = 1'b1;
    lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_size_i = LDST_W;
    lsu_addr_i = '0; lsu_data_i = '0;
    bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
    #1;
    chk("rst req",   32'(bus.req), 32'd0);
    chk("rst be",    32'(bus.be), 32'd0);
    chk("rst addr",  bus.addr, 32'd0);
    chk("rst wdata", bus.wdata, 32'd0);
    chk("rst data",  lsu_data_o, 32'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;

    do_load("LW",  LDST_W,  32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
    do_load("LB",  LDST_B,  32'h0000_0203, 32'h80FF_FF7F, 4'b1000, 32'hFFFF_FF80);
    do_load("LBU", LDST_BU, 32'h0000_0203, 32'h80FF_FF7F, 4'b1000, 32'h0000_0080);
    do_load("LHU", LDST_HU, 32'h0000_0202, 32'h80FF_FF7F, 4'b1100, 32'h0000_80FF);
    do_load("LH",  LDST_H,  32'h0000_0200, 32'h80FF_FF7F, 4'b0011, 32'hFFFF_FF7F);

    // SH with three wait cycles; store operand changes mid-transaction
    @(negedge clk_i);
    lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_size_i = LDST_H;
    lsu_addr_i = 32'h0000_0106; lsu_data_i = 32'h1234_ABCD;
    #1;
    chk("SH c0 stall", 32'(lsu_stall_req_o), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      lsu_data_i = 32'h0;
      bus.gnt = (i == 3);
      #1;
      chk("SH req",   32'(bus.req), 32'd1);
      chk("SH addr",  bus.addr, 32'h0000_0104);
      chk("SH be",    32'(bus.be), 32'hC);
      chk("SH wdata", bus.wdata, 32'hABCD_ABCD);
      chk("SH we",    32'(bus.we), 32'd1);
      chk("SH stall", 32'(lsu_stall_req_o), 32'd1);
    end
    @(negedge clk_i);
    bus.gnt = 1'b0;
    #1;
    chk("SH resp wait stall", 32'(lsu_stall_req_o), 32'd1);
    @(negedge clk_i);
    bus.rvalid = 1'b1; bus.rdata = 32'h5555_5555;
    #1;
    chk("SH done stall", 32'(lsu_stall_req_o), 32'd0);
    chk("SH done data",  lsu_data_o, 32'd0);
    @(negedge clk_i);
    lsu_req_i = 1'b0; bus.rvalid = 1'b0;

    // Misaligned and illegal requests must not reach the bus
    hs0 = n_hs;
    @(negedge clk_i);
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = LDST_W; lsu_addr_i = 32'h0000_0102;
    #1;
    chk("LW mis err",   32'(lsu_err_o), 32'd1);
    chk("LW mis stall", 32'(lsu_stall_req_o), 32'd0);
    @(negedge clk_i);
    bus.gnt = 1'b1;
    #1;
    chk("LW mis req",   32'(bus.req), 32'd0);
    lsu_size_i = 3'b011; lsu_addr_i = 32'h0000_0100;
    #1;
    chk("size011 err",   32'(lsu_err_o), 32'd1);
    chk("size011 stall", 32'(lsu_stall_req_o), 32'd0);
    @(negedge clk_i);
    #1;
    chk("size011 req",   32'(bus.req), 32'd0);
    lsu_we_i = 1'b1; lsu_size_i = LDST_BU;
    #1;
    chk("SBU err", 32'(lsu_err_o), 32'd1);
    @(negedge clk_i);
    #1;
    chk("SBU req", 32'(bus.req), 32'd0);
    chk("err no handshake", 32'(n_hs - hs0), 32'd0);
    lsu_req_i = 1'b0; bus.gnt = 1'b0;
    #1;
    chk("idle err", 32'(lsu_err_o), 32'd0);

    // Reset while waiting in RESP, then a stray rvalid
    @(negedge clk_i);
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = LDST_W; lsu_addr_i = 32'h0000_0300;
    @(negedge clk_i);
    bus.gnt = 1'b1;
    @(negedge clk_i);
    bus.gnt = 1'b0;
    #1;
    chk("pre-rst stall", 32'(lsu_stall_req_o), 32'd1);
    rst_i = 1'b1;
    #1;
    chk("rst mid stall", 32'(lsu_stall_req_o), 32'd0);
    chk("rst mid addr",  bus.addr, 32'd0);
    chk("rst mid be",    32'(bus.be), 32'd0);
    chk("rst mid req",   32'(bus.req), 32'd0);
    chk("rst mid data",  lsu_data_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0; lsu_req_i = 1'b0;
    @(negedge clk_i);
    bus.rvalid = 1'b1; bus.rdata = 32'h1111_2222;
    #1;
    chk("stray data",  lsu_data_o, 32'd0);
    @(negedge clk_i);
    bus.rvalid = 1'b0;
    #1;
    chk("stray req",   32'(bus.req), 32'd0);
    do_load("LW post-rst", LDST_W, 32'h0000_0400, 32'h0BAD_F00D, 4'b1111, 32'h0BAD_F00D);

    // Back-to-back byte stores
    hs0 = n_hs;
    @(negedge clk_i);
    lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_size_i = LDST_B;
    lsu_addr_i = 32'h0000_0001; lsu_data_i = 32'h0000_00AA;
    @(negedge clk_i);
    bus.gnt = 1'b1;
    #1;
    chk("SB1 be",    32'(bus.be), 32'h2);
    chk("SB1 wdata", bus.wdata, 32'hAAAA_AAAA);
    chk("SB1 addr",  bus.addr, 32'h0);
    @(negedge clk_i);
    bus.gnt = 1'b0; bus.rvalid = 1'b1;
    #1;
    chk("SB1 done stall", 32'(lsu_stall_req_o), 32'd0);
    @(negedge clk_i);
    bus.rvalid = 1'b0; lsu_addr_i = 32'h0000_0002; lsu_data_i = 32'h0000_00BB;
    #1;
    chk("SB2 idle req",   32'(bus.req), 32'd0);
    chk("SB2 idle stall", 32'(lsu_stall_req_o), 32'd1);
    @(negedge clk_i);
    bus.gnt = 1'b1;
    #1;
    chk("SB2 req",   32'(bus.req), 32'd1);
    chk("SB2 be",    32'(bus.be), 32'h4);
    chk("SB2 wdata", bus.wdata, 32'hBBBB_BBBB);
    @(negedge clk_i);
    bus.gnt = 1'b0; bus.rvalid = 1'b1;
    #1;
    chk("SB2 done stall", 32'(lsu_stall_req_o), 32'd0);
    @(negedge clk_i);
    bus.rvalid = 1'b0; lsu_req_i = 1'b0;
    #1;
    chk("SB handshakes", 32'(n_hs - hs0), 32'd2);
    chk("SB final req",  32'(bus.req), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
